rc_adder8_reg: RTL and testbench
================================

Name: rc_adder8_reg

Overview:
- Registered 8-bit ripple-carry adder. It computes A + B + Cin through a chain of 1-bit full-adder cells, with carry rippling from bit 0 to bit WIDTH-1.
- Sum, carry-out and flags are captured in output registers on the clock edge.
- Used as a small arithmetic datapath element and as a training/reference block for gate-level ripple-carry timing.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; capture enable
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  registered outputs hold a new result
- s  output  WIDTH  registered sum, low WIDTH bits of a+b+cin
- cout  output  1  registered carry out of bit WIDTH-1 (unsigned overflow)
- ovf  output  1  registered signed overflow
- zero  output  1  registered flag, high when s == 0

Behaviour:
- Reset:
  - rst_n low asynchronously clears s, cout, ovf and out_valid to 0, and sets zero to 1.
  - These values hold while rst_n is low; inputs are ignored.
  - Release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
- Datapath structure:
  - Combinational chain of WIDTH full-adder cells. Each cell is built from two half-adders plus an OR of the two half-adder carries.
  - c[0] = cin; s_i = a_i ^ b_i ^ c[i]; c[i+1] = a_i&b_i | c[i]&(a_i^b_i).
  - No carry-lookahead; the ripple structure is mandatory so gate-level timing reflects the carry chain.
- Flags:
  - Combinational sum_next = low WIDTH bits of the chain.
  - cout_next = c[WIDTH].
  - ovf_next = c[WIDTH] ^ c[WIDTH-1].
  - zero_next = (sum_next == 0).
- Capture:
  - On the rising clk edge with in_valid = 1, register s, cout, ovf and zero from the next values, and set out_valid = 1.
  - On the rising clk edge with in_valid = 0, hold s, cout, ovf and zero, and clear out_valid to 0.
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high with the matching result.
- Throughput: one result per cycle; back-to-back in_valid is fully supported with no bubbles.
- No backpressure; results not consumed are overwritten on the next valid capture.
- Wrap-around: the sum is modulo 2^WIDTH. For example, 0xFF + 0x01 + 0 gives s = 0x00, cout = 1, zero = 1.
- Carry-in: cin = 1 with a = b = 0xFF gives s = 0xFF, cout = 1.
- Reset mid-operation: asserting rst_n during any cycle discards the pending result. out_valid is 0 immediately and stays 0 until a valid capture after release.
- X-handling: the block is not required to filter X on a, b or cin when in_valid = 0, but registers must not update in that case.

Test Plan:
- Reset: hold rst_n low, drive random a/b with in_valid = 1 -> s = 0, cout = 0, ovf = 0, zero = 1, out_valid = 0 throughout. After release, the first valid input appears 1 cycle later.
- Small sums, cin = 0, back-to-back each cycle -> s takes the listed values one cycle later, all with cout = 0:
  - 0+0 -> 0, with zero = 1
  - 1+1 -> 2
  - 3+1 -> 4
  - 3+5 -> 8
  - 7+5 -> 12
  - 7+7 -> 14
  - 4+12 -> 16
  - 4+13 -> 17
- Carry ripple:
  - 0x84+0x0D -> s = 0x91 (145), cout = 0, ovf = 0.
  - 0xF6+0x7D -> s = 0x73 (115), cout = 1, ovf = 0.
  - 0xFF+0x01 -> s = 0x00, cout = 1, zero = 1 (full-length ripple).
- Signed overflow and carry-in:
  - 0x7F+0x01 -> s = 0x80, ovf = 1, cout = 0.
  - 0x80+0x80 -> s = 0x00, ovf = 1, cout = 1.
  - 0xFF+0xFF with cin = 1 -> s = 0xFF, cout = 1, ovf = 0.
- Valid gating: present 0x10+0x20, then drop in_valid while changing a/b -> s stays 0x30, out_valid pulses high for exactly one cycle.
- Reset mid-stream: assert rst_n between two valid inputs -> outputs clear immediately and the pending result is never presented. Exhaustive randomized check of all 65536 a/b pairs with random cin against a+b+cin in a reference model.

Source files
------------

// File: rtl/rc_adder8_reg.sv
// Registered ripple-carry adder: s/cout/ovf/zero = a + b + cin through a chain of full-adder cells.
// Latency: 1 cycle from in_valid sampled high to out_valid high; one result per cycle.
// Backpressure: none; an unread result is overwritten by the next valid capture.

// Half-adder cell: sum and carry of two bits.
module rc_half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

// Full-adder cell: two half-adders with their carries ORed together.
module rc_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  logic g;
  logic pc;

  rc_half_adder u_ha0 (.x_i(a_i), .y_i(b_i), .s_o(p),   .c_o(g));
  rc_half_adder u_ha1 (.x_i(p),   .y_i(c_i), .s_o(s_o), .c_o(pc));

  assign c_o = g | pc;
endmodule

module rc_adder8_reg #(
  parameter int WIDTH = 8  // must be >= 2 so the signed-overflow tap c[WIDTH-1] exists
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Carry chain: c[0] is the carry-in, c[i+1] leaves cell i. Kept as a true
  // ripple so gate-level timing shows the full carry path.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;
  logic             zero_next;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rc_full_adder u_fa (
      .a_i(a[i]),
      .b_i(b[i]),
      .c_i(c[i]),
      .s_o(sum_next[i]),
      .c_o(c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign cout_next = c[WIDTH];
  assign ovf_next  = c[WIDTH] ^ c[WIDTH-1];
  assign zero_next = (sum_next == '0);

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             vld_q, vld_d;

  // Next state: capture the chain on a valid cycle, otherwise hold the result and drop valid.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum_next;
      cout_d = cout_next;
      ovf_d  = ovf_next;
      zero_d = zero_next;
    end
  end

  // Output registers; reset leaves a cleared sum, so zero comes up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rc_adder8_reg.sv
// Bench for rc_adder8_reg: directed tables plus exhaustive a/b sweep against an arithmetic model.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// A reset/idle model tracks what the output registers should hold after each edge.
module tb_rc_adder8_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  logic       zero;

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs should show after the latest edge.
  logic       m_vld;
  logic [7:0] m_s;
  logic       m_cout;
  logic       m_ovf;
  logic       m_zero;

  rc_adder8_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_vld = 1'b0; m_s = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
  endtask

  // Plain integer arithmetic: unsigned sum for s/cout, signed sum for overflow.
  task automatic model_edge(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic ci);
    int u;
    int sg;
    m_vld = v;
    if (v) begin
      u      = int'(aa) + int'(bb) + int'(ci);
      sg     = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
      m_s    = 8'(u % 256);
      m_cout = (u > 255);
      m_ovf  = (sg > 127) || (sg < -128);
      m_zero = ((u % 256) == 0);
    end
  endtask

  // Apply one cycle of inputs, pass the edge, update the model.
  task automatic step(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic ci);
    in_valid = v; a = aa; b = bb; cin = ci;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(v, aa, bb, ci);
    else       model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if ({out_valid, s, cout, ovf, zero} !== 12'b0_00000000_0_0_1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got vld=%b s=%h c=%b o=%b z=%b want 0/00/0/0/1",
                 i, out_valid, s, cout, ovf, zero);
      end
    end
    rst_n = 1'b1;
    step(1'b1, 8'h21, 8'h13, 1'b0);
    checks++;
    if ({out_valid, s, cout, ovf, zero} !== {1'b1, 8'h34, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_capture got vld=%b s=%h c=%b o=%b z=%b want 1/34/0/0/0",
               out_valid, s, cout, ovf, zero);
    end
  endtask

  task automatic test_small_sums();
    logic [7:0] ta [8];
    logic [7:0] tb [8];
    logic [7:0] ts [8];
    ta = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd7, 8'd4,  8'd4};
    tb = '{8'd0, 8'd1, 8'd1, 8'd5, 8'd5, 8'd7, 8'd12, 8'd13};
    ts = '{8'd0, 8'd2, 8'd4, 8'd8, 8'd12, 8'd14, 8'd16, 8'd17};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ta[i], tb[i], 1'b0);
      checks++;
      if ({out_valid, s, cout, ovf, zero} !== {1'b1, ts[i], 1'b0, 1'b0, (i == 0)}) begin
        errors++;
        $display("FAIL small_sum %0d+%0d got vld=%b s=%0d c=%b o=%b z=%b want s=%0d",
                 ta[i], tb[i], out_valid, s, cout, ovf, zero, ts[i]);
      end
    end
  endtask

  task automatic test_carry_and_overflow();
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    logic       tc [6];
    logic [7:0] ts [6];
    logic       tco [6];
    logic       tov [6];
    ta  = '{8'h84, 8'hF6, 8'hFF, 8'h7F, 8'h80, 8'hFF};
    tb  = '{8'h0D, 8'h7D, 8'h01, 8'h01, 8'h80, 8'hFF};
    tc  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    ts  = '{8'h91, 8'h73, 8'h00, 8'h80, 8'h00, 8'hFF};
    tco = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    tov = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ta[i], tb[i], tc[i]);
      checks++;
      if ({out_valid, s, cout, ovf, zero} !== {1'b1, ts[i], tco[i], tov[i], (ts[i] == 8'h00)}) begin
        errors++;
        $display("FAIL carry_ovf %h+%h+%b got s=%h c=%b o=%b z=%b vld=%b want s=%h c=%b o=%b",
                 ta[i], tb[i], tc[i], s, cout, ovf, zero, out_valid, ts[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    step(1'b1, 8'h10, 8'h20, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'h30) begin
      errors++;
      $display("FAIL gate_capture got vld=%b s=%h want 1/30", out_valid, s);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if ({out_valid, s, cout, ovf, zero} !== {1'b0, 8'h30, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL gate_hold cyc=%0d got vld=%b s=%h c=%b o=%b z=%b want 0/30/0/0/0",
                 i, out_valid, s, cout, ovf, zero);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 8'h05, 8'h06, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'h0B) begin
      errors++;
      $display("FAIL mid_first got vld=%b s=%h want 1/0b", out_valid, s);
    end
    // Second operand pair is set up, then reset hits before its edge.
    in_valid = 1'b1; a = 8'h40; b = 8'h02; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, s, cout, ovf, zero} !== 12'b0_00000000_0_0_1) begin
      errors++;
      $display("FAIL mid_async_clear got vld=%b s=%h c=%b o=%b z=%b want 0/00/0/0/1",
               out_valid, s, cout, ovf, zero);
    end
    step(1'b1, 8'h40, 8'h02, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || s !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_edge got vld=%b s=%h want 0/00", out_valid, s);
    end
    rst_n = 1'b1;
    step(1'b0, 8'h40, 8'h02, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || s !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_no_stale got vld=%b s=%h z=%b want 0/00/1", out_valid, s, zero);
    end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 8'(i >> 8), 8'(i), 1'($urandom));
      checks++;
      if ({out_valid, s, cout, ovf, zero} !== {m_vld, m_s, m_cout, m_ovf, m_zero}) begin
        errors++;
        $display("FAIL exhaustive a=%h b=%h cin=%b got vld=%b s=%h c=%b o=%b z=%b want %b/%h/%b/%b/%b",
                 a, b, cin, out_valid, s, cout, ovf, zero, m_vld, m_s, m_cout, m_ovf, m_zero);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_small_sums();
    test_carry_and_overflow();
    test_valid_gating();
    test_reset_midstream();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
